chimera_soc_fixture: RTL and testbench



---
 rtl/chimera_fixture_pkg.sv | 49 ++++
 rtl/chimera_fixture_uart_rx.sv | 90 +++++++++
 rtl/chimera_soc_fixture.sv | 127 ++++++++++++
 tb/tb_chimera_soc_fixture.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chimera_fixture_pkg.sv
`default_nettype none
// ============================================================================
// Module  : chimera_fixture_pkg
// Brief   : Shared types, mode encodings and config table for the SoC fixture.
// Revision: 1.0
// ============================================================================
package chimera_fixture_pkg;

  typedef enum logic [2:0] {
    ST_HOLD  = 3'd0,
    ST_CHECK = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  localparam logic [1:0] c_BOOT_IDLE  = 2'd0;
  localparam logic [1:0] c_BOOT_SD    = 2'd1;
  localparam logic [1:0] c_BOOT_AUTO0 = 2'd2;
  localparam logic [1:0] c_BOOT_AUTO1 = 2'd3;

  localparam logic [1:0] c_PRELOAD_JTAG  = 2'd0;
  localparam logic [1:0] c_PRELOAD_RSVD1 = 2'd1;
  localparam logic [1:0] c_PRELOAD_UART  = 2'd2;
  localparam logic [1:0] c_PRELOAD_RSVD3 = 2'd3;

  typedef struct packed {
    logic [31:0] scratch_addr;
  } cfg_t;

  function automatic cfg_t get_cfg(input int idx);
    cfg_t cfg;
    case (idx)
      1:       cfg.scratch_addr = 32'h0300_0010;
      default: cfg.scratch_addr = 32'h0300_0008;
    endcase
    return cfg;
  endfunction

  // SD boot is not modelled by the fixture; idle boot needs a real preload path.
  function automatic logic mode_faults(input logic [1:0] boot, input logic [1:0] preload);
    return (boot == c_BOOT_SD) ||
           ((boot == c_BOOT_IDLE) &&
            ((preload == c_PRELOAD_RSVD1) || (preload == c_PRELOAD_RSVD3)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/chimera_fixture_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : chimera_fixture_uart_rx
// Brief   : Mid-bit sampling 8N1 receiver watching the SoC UART TX line.
// Revision: 1.0
// ============================================================================
module chimera_fixture_uart_rx #(
  parameter int ClkPerBit = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       i_en,
  input  logic       i_rx,
  output logic       o_reading,
  output logic [7:0] o_byte,
  output logic       o_valid
);

  localparam int              c_TW        = $clog2(ClkPerBit);
  localparam logic [c_TW-1:0] c_BIT_LAST  = c_TW'(ClkPerBit - 1);
  localparam logic [c_TW-1:0] c_HALF_LAST = c_TW'(ClkPerBit / 2 - 1);
  localparam logic [3:0]      c_STOP_IDX  = 4'd9;

  logic            r_rx_q;
  logic            r_rx_prev;
  logic            r_reading;
  logic            r_valid;
  logic [c_TW-1:0] r_timer;
  logic [3:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_byte;
  logic            w_start;

  assign w_start = i_en && !r_reading && r_rx_prev && !r_rx_q;

  // Line idles high, so reset the synchroniser to 1 to avoid a false start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_q    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_q    <= i_rx;
      r_rx_prev <= r_rx_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_reading <= 1'b0;
      r_valid   <= 1'b0;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_byte    <= '0;
    end else begin
      r_valid <= 1'b0;
      if (!i_en) begin
        r_reading <= 1'b0;
        r_timer   <= '0;
        r_bit_idx <= '0;
      end else if (w_start) begin
        r_reading <= 1'b1;
        r_timer   <= c_HALF_LAST;
        r_bit_idx <= '0;
      end else if (r_reading) begin
        if (r_timer != '0) begin
          r_timer <= r_timer - 1'b1;
        end else begin
          r_timer   <= c_BIT_LAST;
          r_bit_idx <= r_bit_idx + 4'd1;
          if (r_bit_idx == 4'd0) begin
            if (r_rx_q) r_reading <= 1'b0;
          end else if (r_bit_idx == c_STOP_IDX) begin
            r_reading <= 1'b0;
            r_byte    <= r_shift;
            r_valid   <= 1'b1;
          end else begin
            r_shift <= {r_rx_q, r_shift[7:1]};
          end
        end
      end
    end
  end

  assign o_reading = r_reading;
  assign o_byte    = r_byte;
  assign o_valid   = r_valid;

endmodule
`default_nettype wire

// File: rtl/chimera_soc_fixture.sv
`default_nettype none
// ============================================================================
// Module  : chimera_soc_fixture
// Brief   : SoC reset/boot sequencer, EOC detector and UART-aware finish gate.
// Revision: 1.0
// ============================================================================
module chimera_soc_fixture
  import chimera_fixture_pkg::*;
#(
  parameter int SelectedCfg = 0,
  parameter int ResetCycles = 16,
  parameter int ClkPerBit   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  boot_mode_i,
  input  logic [1:0]  preload_mode_i,
  output logic        soc_rst_no,
  output logic [1:0]  boot_mode_o,
  input  logic        reg_we_i,
  input  logic [31:0] reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  input  logic        uart_tx_i,
  output logic        uart_reading_byte_o,
  output logic [7:0]  uart_byte_o,
  output logic        uart_byte_valid_o,
  output logic        eoc_o,
  output logic [31:0] exit_code_o,
  output logic        fault_o,
  output logic        finish_o
);

  localparam cfg_t            c_CFG          = get_cfg(SelectedCfg);
  localparam logic [31:0]     c_SCRATCH_ADDR = c_CFG.scratch_addr;
  localparam int              c_CW           = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;
  localparam logic [c_CW-1:0] c_CNT_LAST     = c_CW'(ResetCycles - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic [1:0]      r_boot_mode;
  logic            r_eoc;
  logic [31:0]     r_exit_code;
  logic            w_eoc_hit;
  logic            w_soc_rst_n;
  logic            w_fault;
  logic            w_finish;
  logic            w_uart_reading;

  assign w_eoc_hit = reg_we_i && (reg_addr_i == c_SCRATCH_ADDR) && reg_wdata_i[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_HOLD;
      r_cnt       <= '0;
      r_boot_mode <= '0;
      r_eoc       <= 1'b0;
      r_exit_code <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_HOLD) begin
        r_cnt <= r_cnt + 1'b1;
        // HOLD is only entered from reset, so cnt==0 marks its first cycle.
        if (r_cnt == '0) r_boot_mode <= boot_mode_i;
      end
      if ((r_state == ST_RUN) && w_eoc_hit) begin
        r_eoc       <= 1'b1;
        r_exit_code <= {1'b0, reg_wdata_i[31:1]};
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_soc_rst_n = 1'b0;
    w_fault     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (r_cnt == c_CNT_LAST) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        w_state_nxt = mode_faults(r_boot_mode, preload_mode_i) ? ST_FAULT : ST_RUN;
      end
      ST_RUN: begin
        w_soc_rst_n = 1'b1;
        if (w_eoc_hit) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_soc_rst_n = 1'b1;
        if (!w_uart_reading) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_soc_rst_n = 1'b1;
        w_finish    = 1'b1;
      end
      ST_FAULT: begin
        w_fault = 1'b1;
      end
      default: begin
        w_state_nxt = ST_HOLD;
      end
    endcase
  end

  chimera_fixture_uart_rx #(
    .ClkPerBit (ClkPerBit)
  ) u_uart_rx (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_en      (w_soc_rst_n),
    .i_rx      (uart_tx_i),
    .o_reading (w_uart_reading),
    .o_byte    (uart_byte_o),
    .o_valid   (uart_byte_valid_o)
  );

  assign soc_rst_no          = w_soc_rst_n;
  assign boot_mode_o         = r_boot_mode;
  assign uart_reading_byte_o = w_uart_reading;
  assign eoc_o               = r_eoc;
  assign exit_code_o         = r_exit_code;
  assign fault_o             = w_fault;
  assign finish_o            = w_finish;

endmodule
`default_nettype wire

// File: tb/tb_chimera_soc_fixture.sv
`default_nettype none
// ============================================================================
// Module  : tb_chimera_soc_fixture
// Brief   : Directed self-checking bench for chimera_soc_fixture.
// Revision: 1.0
// ============================================================================
module tb_chimera_soc_fixture;

  localparam int          c_RESET_CYCLES = 16;
  localparam int          c_CPB          = 16;
  localparam logic [31:0] c_SCRATCH      = 32'h0300_0008;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  boot_mode = 2'd0;
  logic [1:0]  preload = 2'd0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        uart_tx = 1'b1;
  logic        soc_rst_n;
  logic [1:0]  boot_mode_out;
  logic        reading;
  logic [7:0]  ubyte;
  logic        uvalid;
  logic        eoc;
  logic [31:0] exit_code;
  logic        fault;
  logic        finish;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  chimera_soc_fixture #(
    .SelectedCfg (0),
    .ResetCycles (c_RESET_CYCLES),
    .ClkPerBit   (c_CPB)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .boot_mode_i         (boot_mode),
    .preload_mode_i      (preload),
    .soc_rst_no          (soc_rst_n),
    .boot_mode_o         (boot_mode_out),
    .reg_we_i            (we),
    .reg_addr_i          (addr),
    .reg_wdata_i         (wdata),
    .uart_tx_i           (uart_tx),
    .uart_reading_byte_o (reading),
    .uart_byte_o         (ubyte),
    .uart_byte_valid_o   (uvalid),
    .eoc_o               (eoc),
    .exit_code_o         (exit_code),
    .fault_o             (fault),
    .finish_o            (finish)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step after the edge that sees rst low for the first time minus one.
  task automatic start_sequence(input logic [1:0] boot, input logic [1:0] pre);
    rst = 1'b1; boot_mode = boot; preload = pre;
    we = 1'b0; addr = '0; wdata = '0; uart_tx = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; boot_mode = 2'd2; preload = 2'd0; uart_tx = 1'b1;
    tick(); tick();
    n_cmp++; if (soc_rst_n !== 1'b0) begin n_err++; $display("FAIL rst_soc_rst_n: got %b want 0", soc_rst_n); end
    n_cmp++; if (boot_mode_out !== 2'd0) begin n_err++; $display("FAIL rst_boot_mode: got %0d want 0", boot_mode_out); end
    n_cmp++; if (reading !== 1'b0) begin n_err++; $display("FAIL rst_reading: got %b want 0", reading); end
    n_cmp++; if (ubyte !== 8'h00) begin n_err++; $display("FAIL rst_byte: got %h want 00", ubyte); end
    n_cmp++; if (uvalid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", uvalid); end
    n_cmp++; if (eoc !== 1'b0) begin n_err++; $display("FAIL rst_eoc: got %b want 0", eoc); end
    n_cmp++; if (exit_code !== 32'h0) begin n_err++; $display("FAIL rst_exit: got %h want 0", exit_code); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %b want 0", fault); end
    n_cmp++; if (finish !== 1'b0) begin n_err++; $display("FAIL rst_finish: got %b want 0", finish); end
  endtask

  task automatic test_boot_idle_eoc();
    start_sequence(2'd0, 2'd0);
    repeat (c_RESET_CYCLES) tick();
    n_cmp++; if (soc_rst_n !== 1'b0) begin n_err++; $display("FAIL idle_soc_still_held: got %b want 0", soc_rst_n); end
    tick();
    n_cmp++; if (soc_rst_n !== 1'b1) begin n_err++; $display("FAIL idle_soc_release: got %b want 1", soc_rst_n); end
    n_cmp++; if (boot_mode_out !== 2'd0) begin n_err++; $display("FAIL idle_boot_mode: got %0d want 0", boot_mode_out); end
    we = 1'b1; addr = c_SCRATCH; wdata = 32'h0000_0001;
    tick();
    we = 1'b0;
    n_cmp++; if (eoc !== 1'b1) begin n_err++; $display("FAIL idle_eoc: got %b want 1", eoc); end
    n_cmp++; if (exit_code !== 32'h0) begin n_err++; $display("FAIL idle_exit: got %h want 0", exit_code); end
    n_cmp++; if (finish !== 1'b0) begin n_err++; $display("FAIL idle_finish_early: got %b want 0", finish); end
    tick();
    n_cmp++; if (finish !== 1'b1) begin n_err++; $display("FAIL idle_finish: got %b want 1", finish); end
  endtask

  task automatic test_boot_auto();
    start_sequence(2'd2, 2'd0);
    tick();
    boot_mode = 2'd3;
    repeat (c_RESET_CYCLES) tick();
    n_cmp++; if (soc_rst_n !== 1'b1) begin n_err++; $display("FAIL auto_soc_release: got %b want 1", soc_rst_n); end
    n_cmp++; if (boot_mode_out !== 2'd2) begin n_err++; $display("FAIL auto_boot_latched: got %0d want 2", boot_mode_out); end
    we = 1'b1; addr = c_SCRATCH; wdata = 32'h0000_0055;
    tick();
    we = 1'b0;
    n_cmp++; if (exit_code !== 32'h0000_002A) begin n_err++; $display("FAIL auto_exit: got %h want 0000002a", exit_code); end
    tick();
    n_cmp++; if (finish !== 1'b1) begin n_err++; $display("FAIL auto_finish: got %b want 1", finish); end
    we = 1'b1; addr = c_SCRATCH; wdata = 32'h0000_0003;
    tick();
    we = 1'b0;
    tick();
    n_cmp++; if (exit_code !== 32'h0000_002A) begin n_err++; $display("FAIL auto_exit_once: got %h want 0000002a", exit_code); end
  endtask

  task automatic test_no_eoc_and_glitch();
    int n_valid;
    start_sequence(2'd0, 2'd2);
    repeat (c_RESET_CYCLES + 1) tick();
    we = 1'b1; addr = c_SCRATCH; wdata = 32'h0000_0002;
    tick();
    we = 1'b1; addr = c_SCRATCH + 32'd4; wdata = 32'h0000_0001;
    tick();
    we = 1'b0;
    tick();
    n_cmp++; if (eoc !== 1'b0) begin n_err++; $display("FAIL noeoc_eoc: got %b want 0", eoc); end
    n_cmp++; if (exit_code !== 32'h0) begin n_err++; $display("FAIL noeoc_exit: got %h want 0", exit_code); end
    uart_tx = 1'b0;
    tick();
    uart_tx = 1'b1;
    tick();
    n_cmp++; if (reading !== 1'b1) begin n_err++; $display("FAIL glitch_start_seen: got %b want 1", reading); end
    n_valid = 0;
    for (int i = 0; i < 3 * c_CPB; i++) begin
      tick();
      if (uvalid === 1'b1) n_valid++;
    end
    n_cmp++; if (n_valid !== 0) begin n_err++; $display("FAIL glitch_valid_pulses: got %0d want 0", n_valid); end
    n_cmp++; if (reading !== 1'b0) begin n_err++; $display("FAIL glitch_aborted: got %b want 0", reading); end
    n_cmp++; if (finish !== 1'b0) begin n_err++; $display("FAIL noeoc_finish: got %b want 0", finish); end
  endtask

  task automatic test_uart_eoc();
    logic [9:0] frame;
    logic [7:0] got_byte;
    int         n_valid;
    logic       prev_valid;
    frame = {1'b1, 8'hA5, 1'b0};
    got_byte = 8'h00;
    n_valid = 0;
    prev_valid = 1'b0;
    start_sequence(2'd0, 2'd2);
    repeat (c_RESET_CYCLES + 1) tick();
    for (int i = 0; i < 11 * c_CPB; i++) begin
      uart_tx = ((i / c_CPB) < 10) ? frame[i / c_CPB] : 1'b1;
      if (i == 4 * c_CPB) begin
        we = 1'b1; addr = c_SCRATCH; wdata = 32'h0000_0007;
      end
      tick();
      we = 1'b0;
      if (i == 0) begin
        n_cmp++; if (reading !== 1'b0) begin n_err++; $display("FAIL uart_reading_lag: got %b want 0", reading); end
      end
      if (i == 1) begin
        n_cmp++; if (reading !== 1'b1) begin n_err++; $display("FAIL uart_reading_rise: got %b want 1", reading); end
      end
      if (i == 4 * c_CPB) begin
        n_cmp++; if (eoc !== 1'b1) begin n_err++; $display("FAIL uart_eoc: got %b want 1", eoc); end
        n_cmp++; if (exit_code !== 32'h3) begin n_err++; $display("FAIL uart_exit: got %h want 3", exit_code); end
        n_cmp++; if (finish !== 1'b0) begin n_err++; $display("FAIL uart_finish_mid_byte: got %b want 0", finish); end
      end
      if (prev_valid) begin
        n_cmp++; if (finish !== 1'b1) begin n_err++; $display("FAIL uart_finish_after_byte: got %b want 1", finish); end
      end
      prev_valid = uvalid;
      if (uvalid === 1'b1) begin
        n_valid++;
        got_byte = ubyte;
        n_cmp++; if (finish !== 1'b0) begin n_err++; $display("FAIL uart_finish_at_stop: got %b want 0", finish); end
        n_cmp++; if (reading !== 1'b0) begin n_err++; $display("FAIL uart_reading_fall: got %b want 0", reading); end
      end
    end
    n_cmp++; if (n_valid !== 1) begin n_err++; $display("FAIL uart_valid_pulses: got %0d want 1", n_valid); end
    n_cmp++; if (got_byte !== 8'hA5) begin n_err++; $display("FAIL uart_byte: got %h want a5", got_byte); end
    n_cmp++; if (finish !== 1'b1) begin n_err++; $display("FAIL uart_finish_end: got %b want 1", finish); end
  endtask

  task automatic test_fault();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) start_sequence(2'd1, 2'd0);
      else        start_sequence(2'd0, 2'd3);
      repeat (c_RESET_CYCLES) tick();
      n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL fault%0d_in_hold: got %b want 0", k, fault); end
      tick();
      n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL fault%0d_flag: got %b want 1", k, fault); end
      n_cmp++; if (soc_rst_n !== 1'b0) begin n_err++; $display("FAIL fault%0d_soc: got %b want 0", k, soc_rst_n); end
      repeat (10) tick();
      n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL fault%0d_sticky: got %b want 1", k, fault); end
      n_cmp++; if (soc_rst_n !== 1'b0) begin n_err++; $display("FAIL fault%0d_soc_held: got %b want 0", k, soc_rst_n); end
      n_cmp++; if (finish !== 1'b0) begin n_err++; $display("FAIL fault%0d_finish: got %b want 0", k, finish); end
    end
  endtask

  task automatic test_reset_in_drain();
    start_sequence(2'd0, 2'd0);
    repeat (c_RESET_CYCLES + 1) tick();
    uart_tx = 1'b0;
    repeat (3) tick();
    we = 1'b1; addr = c_SCRATCH; wdata = 32'h8000_0003;
    tick();
    we = 1'b0;
    n_cmp++; if (exit_code !== 32'h4000_0001) begin n_err++; $display("FAIL drain_exit: got %h want 40000001", exit_code); end
    n_cmp++; if (reading !== 1'b1) begin n_err++; $display("FAIL drain_reading: got %b want 1", reading); end
    tick();
    n_cmp++; if (finish !== 1'b0) begin n_err++; $display("FAIL drain_finish_held: got %b want 0", finish); end
    rst = 1'b1; boot_mode = 2'd2;
    tick();
    n_cmp++; if (soc_rst_n !== 1'b0) begin n_err++; $display("FAIL drain_rst_soc: got %b want 0", soc_rst_n); end
    n_cmp++; if (boot_mode_out !== 2'd0) begin n_err++; $display("FAIL drain_rst_boot: got %0d want 0", boot_mode_out); end
    n_cmp++; if (reading !== 1'b0) begin n_err++; $display("FAIL drain_rst_reading: got %b want 0", reading); end
    n_cmp++; if (eoc !== 1'b0) begin n_err++; $display("FAIL drain_rst_eoc: got %b want 0", eoc); end
    n_cmp++; if (exit_code !== 32'h0) begin n_err++; $display("FAIL drain_rst_exit: got %h want 0", exit_code); end
    n_cmp++; if (finish !== 1'b0) begin n_err++; $display("FAIL drain_rst_finish: got %b want 0", finish); end
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL drain_rst_fault: got %b want 0", fault); end
    uart_tx = 1'b1;
    rst = 1'b0;
    repeat (c_RESET_CYCLES) tick();
    n_cmp++; if (soc_rst_n !== 1'b0) begin n_err++; $display("FAIL restart_hold: got %b want 0", soc_rst_n); end
    tick();
    n_cmp++; if (soc_rst_n !== 1'b1) begin n_err++; $display("FAIL restart_release: got %b want 1", soc_rst_n); end
    n_cmp++; if (boot_mode_out !== 2'd2) begin n_err++; $display("FAIL restart_boot: got %0d want 2", boot_mode_out); end
  endtask

  initial begin
    test_reset();
    test_boot_idle_eoc();
    test_boot_auto();
    test_no_eoc_and_glitch();
    test_uart_eoc();
    test_fault();
    test_reset_in_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
